scan_order_gen: RTL and testbench
=================================

Name: scan_order_gen

Overview:
Parametrised scan-order address generator for square coefficient/pixel blocks of side 2^LOG2_DIM. It generates raster, Morton (Z), column or zigzag element order. It starts a block on a sob pulse and emits one row/col index per accepted beat over a valid/ready handshake. It sits between block-level control and the coefficient buffer read port, and supersedes the fixed 8x8 Z-scan counter.

Parameters:
LOG2_DIM, 3, log2 of block side; legal 1..5 (2x2 .. 32x32); DIM = 2^LOG2_DIM.
ID_W, 2*LOG2_DIM, derived localparam (not overridable): index width.

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
sob  in  1  start-of-block pulse, sampled each clk
mode  in  2  scan mode, sampled only when sob=1 (0 raster, 1 Morton, 2 column, 3 zigzag)
zid_rdy  in  1  consumer ready
zid  out  ID_W  element index = {zrow, zcol} (row-major address)
zrow  out  LOG2_DIM  row of current element
zcol  out  LOG2_DIM  column of current element
zid_vld  out  1  zid/zrow/zcol valid
zid_last  out  1  current element is the final element of the block (cnt = DIM*DIM-1)
busy  out  1  block in progress (equals zid_vld)

Behaviour:
- Reset (async, rstn=0): state IDLE; cnt=0; mode_q=0; zrow=zcol=0; zigzag dir=up. Outputs zid=0, zid_vld=0, zid_last=0, busy=0.
- States: IDLE, ACTIVE. Element counter cnt is ID_W bits, 0..DIM*DIM-1. Transfer = zid_vld & zid_rdy.
- IDLE: sob=1 -> ACTIVE, mode_q<=mode, cnt<=0. zid_vld rises on the next cycle with element 0 (index 0 in every mode). Latency sob -> first valid = 1 cycle.
- ACTIVE, no transfer: all outputs held stable. No change while stalled.
- ACTIVE, transfer, not last: cnt++ and position steps to the next element.
- ACTIVE, transfer on last:
  - sob=1 same cycle: stay ACTIVE, reload cnt=0, capture new mode. Back-to-back, zero bubble.
  - sob=0: go to IDLE; zid_vld=0 next cycle.
- ACTIVE, sob=1 not on last: abort and restart at element 0 with the newly sampled mode next cycle. A transfer in the same cycle still counts as delivered. sob has priority over the normal step.
- Position per mode (lo = cnt[LOG2_DIM-1:0], hi = cnt[ID_W-1:LOG2_DIM]):
  - raster: zrow=hi, zcol=lo.
  - column: zrow=lo, zcol=hi.
  - Morton: zrow = odd bits of cnt (cnt[1], cnt[3], ...), zcol = even bits (cnt[0], cnt[2], ...); MSB-first concatenation.
  - zigzag (JPEG), sequential walker on (r,c,dir), start (0,0) dir=up.
    - up step: if c==DIM-1 {r++, dir=down}; else if r==0 {c++, dir=down}; else {r--, c++}.
    - down step: if r==DIM-1 {c++, dir=up}; else if c==0 {r++, dir=up}; else {r++, c--}.
- zid_last is derived from cnt and is independent of mode.
- All outputs are registered or decoded from registered state only. No combinational path from zid_rdy/sob to outputs.
- sob in IDLE while rstn low is ignored.

Optional Feature:
SCAN_ZIGZAG_EN
- Defined: mode 3 selects the zigzag walker as above.
- Undefined: walker logic is not instantiated; mode 3 is treated as raster (mode_q stores 0). All other behaviour is unchanged.

Decomposition:
- Package scan_pkg:
  - scan_mode_e enum: SCAN_RASTER=2'd0, SCAN_MORTON=2'd1, SCAN_COLUMN=2'd2, SCAN_ZIGZAG=2'd3.
  - Function deinterleave (even/odd bit extraction, generic width).
  - Zigzag dir enum: DIR_UP, DIR_DOWN.
- One sub-module: scan_zigzag_walk (params LOG2_DIM; inputs clk, rstn, restart, step; outputs r, c). Instantiated only under SCAN_ZIGZAG_EN.

Test Plan:
- LOG2_DIM=3, mode=1, zid_rdy=1, sob pulse -> zid_vld next cycle; zid = 0,1,8,9,2,3,10,11,16,... ; zid_last on 64th beat (zid=63); zid_vld low afterwards.
- mode=3 (SCAN_ZIGZAG_EN defined) -> zid = 0,1,8,16,9,2,3,10,17,24,...,55,62,63; exactly 64 beats. Undefined -> 0,1,2,...,63.
- mode=2 with zid_rdy toggled 1,0,0,1 -> sequence 0,8,16,...,56,1,9,...; outputs held stable on every stalled cycle; 64 transfers total.
- sob asserted coincident with the final transfer (mode 0 then mode 1) -> no zid_vld gap; next beat zid=0 and following beats in Morton order.
- sob mid-block at cnt=20 -> next cycle zid=0 with the new mode; zid_last appears only after 64 further transfers.
- rstn dropped mid-block (cnt=30) -> zid_vld, zid, zid_last = 0 immediately; after release, no output until the next sob.

Source files
------------

// File: rtl/scan_order_gen_pkg.sv
// Shared types and helpers for the scan-order address generator.
// SCAN_ZIGZAG_EN only affects the top and walker; this package is build-independent.
package scan_pkg;

    typedef enum logic [1:0] {
        SCAN_RASTER = 2'd0,
        SCAN_MORTON = 2'd1,
        SCAN_COLUMN = 2'd2,
        SCAN_ZIGZAG = 2'd3
    } scan_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } zz_dir_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } scan_state_e;

    localparam int MAX_LOG2_DIM = 5;
    localparam int MAX_ID_W     = 2 * MAX_LOG2_DIM;

    // Gathers the even bits of v, LSB first; pass v >> 1 to gather the odd bits.
    function automatic logic [MAX_LOG2_DIM-1:0] deinterleave(input logic [MAX_ID_W-1:0] v);
        logic [MAX_LOG2_DIM-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_LOG2_DIM; i++) begin
            res[i] = v[2*i];
        end
        return res;
    endfunction

endpackage

// File: rtl/scan_order_gen_zigzag_walk.sv
// Sequential JPEG zigzag walker over a DIM x DIM block; only instantiated when
// SCAN_ZIGZAG_EN is defined.
module scan_zigzag_walk
    import scan_pkg::*;
#(
    parameter int LOG2_DIM = 3
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                restart,
    input  logic                step,
    output logic [LOG2_DIM-1:0] r,
    output logic [LOG2_DIM-1:0] c
);

    localparam logic [LOG2_DIM-1:0] EDGE = '1;

    zz_dir_e dir_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r     <= '0;
            c     <= '0;
            dir_q <= DIR_UP;
        end else if (restart) begin
            r     <= '0;
            c     <= '0;
            dir_q <= DIR_UP;
        end else if (step) begin
            if (dir_q == DIR_UP) begin
                // Edge checks on the right column take precedence over the top row.
                if (c == EDGE) begin
                    r     <= r + 1'b1;
                    dir_q <= DIR_DOWN;
                end else if (r == '0) begin
                    c     <= c + 1'b1;
                    dir_q <= DIR_DOWN;
                end else begin
                    r <= r - 1'b1;
                    c <= c + 1'b1;
                end
            end else begin
                if (r == EDGE) begin
                    c     <= c + 1'b1;
                    dir_q <= DIR_UP;
                end else if (c == '0) begin
                    r     <= r + 1'b1;
                    dir_q <= DIR_UP;
                end else begin
                    r <= r + 1'b1;
                    c <= c - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/scan_order_gen.sv
// Scan-order element index generator (raster, Morton, column, zigzag) with valid/ready output.
// Zigzag order requires SCAN_ZIGZAG_EN; without it mode 3 falls back to raster.
//
// state     | meaning
// ST_IDLE   | no block in progress, outputs invalid, waiting for sob
// ST_ACTIVE | presenting element cnt of the current block
module scan_order_gen
    import scan_pkg::*;
#(
    parameter  int LOG2_DIM = 3,
    localparam int ID_W     = 2 * LOG2_DIM
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                sob,
    input  logic [1:0]          mode,
    input  logic                zid_rdy,
    output logic [ID_W-1:0]     zid,
    output logic [LOG2_DIM-1:0] zrow,
    output logic [LOG2_DIM-1:0] zcol,
    output logic                zid_vld,
    output logic                zid_last,
    output logic                busy
);

    localparam logic [ID_W-1:0] LAST_CNT = '1;

    scan_state_e     state_q, state_d;
    logic [ID_W-1:0] cnt_q, cnt_d;
    scan_mode_e      mode_q, mode_d;
    scan_mode_e      sob_mode;
    logic            xfer;
    logic            is_last;

`ifdef SCAN_ZIGZAG_EN
    assign sob_mode = scan_mode_e'(mode);
`else
    assign sob_mode = (mode == 2'd3) ? SCAN_RASTER : scan_mode_e'(mode);
`endif

    assign xfer    = (state_q == ST_ACTIVE) && zid_rdy;
    assign is_last = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= SCAN_RASTER;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    // sob wins over the normal step in both states, which also gives the zero-bubble chain.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (sob) begin
                    state_d = ST_ACTIVE;
                    mode_d  = sob_mode;
                    cnt_d   = '0;
                end
            end
            ST_ACTIVE: begin
                if (sob) begin
                    mode_d = sob_mode;
                    cnt_d  = '0;
                end else if (xfer) begin
                    if (is_last) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ID_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef SCAN_ZIGZAG_EN
    logic [LOG2_DIM-1:0] zz_r, zz_c;

    scan_zigzag_walk #(
        .LOG2_DIM(LOG2_DIM)
    ) u_zigzag_walk (
        .clk    (clk),
        .rstn   (rstn),
        .restart(sob || (xfer && is_last)),
        .step   (xfer && !is_last && !sob),
        .r      (zz_r),
        .c      (zz_c)
    );
`endif

    always_comb begin
        logic [MAX_ID_W-1:0] cnt_ext;
        cnt_ext = MAX_ID_W'(cnt_q);
        zrow    = cnt_q[ID_W-1:LOG2_DIM];
        zcol    = cnt_q[LOG2_DIM-1:0];
        case (mode_q)
            SCAN_COLUMN: begin
                zrow = cnt_q[LOG2_DIM-1:0];
                zcol = cnt_q[ID_W-1:LOG2_DIM];
            end
            SCAN_MORTON: begin
                zrow = LOG2_DIM'(deinterleave(cnt_ext >> 1));
                zcol = LOG2_DIM'(deinterleave(cnt_ext));
            end
`ifdef SCAN_ZIGZAG_EN
            SCAN_ZIGZAG: begin
                zrow = zz_r;
                zcol = zz_c;
            end
`endif
            default: ;
        endcase
    end

    assign zid      = {zrow, zcol};
    assign zid_vld  = (state_q == ST_ACTIVE);
    assign busy     = zid_vld;
    assign zid_last = zid_vld && is_last;

endmodule

// File: tb/tb_scan_order_gen.sv
// Scoreboard bench for scan_order_gen at LOG2_DIM=3; expected zigzag order follows
// SCAN_ZIGZAG_EN the same way the design does.
module tb_scan_order_gen;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sob = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       zid_rdy = 1'b0;
    logic [5:0] zid;
    logic [2:0] zrow, zcol;
    logic       zid_vld, zid_last, busy;

    always #5 clk = ~clk;

    scan_order_gen #(.LOG2_DIM(3)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .sob     (sob),
        .mode    (mode),
        .zid_rdy (zid_rdy),
        .zid     (zid),
        .zrow    (zrow),
        .zcol    (zcol),
        .zid_vld (zid_vld),
        .zid_last(zid_last),
        .busy    (busy)
    );

    typedef struct packed {
        logic [5:0] id;
        logic       last;
    } exp_t;

    exp_t       sbq[$];
    exp_t       e;
    int         total = 0;
    int         bad = 0;
    logic [5:0] zz_tab[64];

    // Zigzag reference built by anti-diagonals: odd diagonals run top-right to
    // bottom-left, even diagonals bottom-left to top-right.
    task automatic build_zz();
        int idx = 0;
        for (int s = 0; s <= 14; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin
                    zz_tab[idx] = {3'(r), 3'(s - r)};
                    idx++;
                end
            end else begin
                for (int r = hi; r >= lo; r--) begin
                    zz_tab[idx] = {3'(r), 3'(s - r)};
                    idx++;
                end
            end
        end
    endtask

    function automatic logic [5:0] ref_id(int m, int k);
        logic [5:0] kk;
        logic [5:0] id;
        kk = 6'(k);
        case (m)
            1: id = {kk[5], kk[3], kk[1], kk[4], kk[2], kk[0]};
            2: id = {kk[2:0], kk[5:3]};
`ifdef SCAN_ZIGZAG_EN
            3: id = zz_tab[k];
`endif
            default: id = kk;
        endcase
        return id;
    endfunction

    task automatic push_block(int m);
        for (int k = 0; k < 64; k++) begin
            sbq.push_back('{id: ref_id(m, k), last: (k == 63)});
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; sob = 1'b1; mode = 2'd1; zid_rdy = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (zid_vld !== 1'b0 || zid !== 6'd0 || zid_last !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got vld=%b zid=%0d last=%b busy=%b want all 0", zid_vld, zid, zid_last, busy);
        end
        rstn = 1'b1; sob = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (zid_vld !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_start got vld=%b want 0", zid_vld);
            end
        end
    endtask

    task automatic test_order(input string name, input logic [1:0] m);
        int cyc = 0;
        push_block(int'(m));
        @(negedge clk); sob = 1'b1; mode = m; zid_rdy = 1'b1;
        @(negedge clk); sob = 1'b0;
        total++;
        if (zid_vld !== 1'b1) begin
            bad++;
            $display("FAIL %s_latency got vld=%b want 1", name, zid_vld);
        end
        while (sbq.size() > 0 && cyc < 200) begin
            if (zid_vld) begin
                e = sbq[0];
                total++;
                if (zid !== e.id || zid_last !== e.last || {zrow, zcol} !== e.id || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s_beat got zid=%0d last=%b row=%0d col=%0d want zid=%0d last=%b", name, zid, zid_last, zrow, zcol, e.id, e.last);
                end
                if (zid_rdy) e = sbq.pop_front();
            end
            cyc++;
            @(negedge clk);
        end
        total++;
        if (sbq.size() != 0 || zid_vld !== 1'b0) begin
            bad++;
            $display("FAIL %s_end got left=%0d vld=%b want left=0 vld=0", name, sbq.size(), zid_vld);
        end
        sbq.delete();
    endtask

    task automatic test_column_stall();
        int cyc = 0;
        int xfers = 0;
        push_block(2);
        @(negedge clk); sob = 1'b1; mode = 2'd2; zid_rdy = 1'b1;
        @(negedge clk); sob = 1'b0;
        while (sbq.size() > 0 && cyc < 400) begin
            zid_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            total++;
            e = sbq[0];
            if (zid_vld !== 1'b1 || zid !== e.id || zid_last !== e.last || {zrow, zcol} !== e.id) begin
                bad++;
                $display("FAIL stall_beat got vld=%b zid=%0d last=%b want vld=1 zid=%0d last=%b rdy=%b", zid_vld, zid, zid_last, e.id, e.last, zid_rdy);
            end
            if (zid_vld && zid_rdy) begin
                e = sbq.pop_front();
                xfers++;
            end
            cyc++;
            @(negedge clk);
        end
        zid_rdy = 1'b1;
        total++;
        if (xfers != 64 || zid_vld !== 1'b0) begin
            bad++;
            $display("FAIL stall_count got xfers=%0d vld=%b want 64 and 0", xfers, zid_vld);
        end
        sbq.delete();
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        push_block(0);
        push_block(1);
        @(negedge clk); sob = 1'b1; mode = 2'd0; zid_rdy = 1'b1;
        @(negedge clk); sob = 1'b0; mode = 2'd1;
        while (sbq.size() > 0 && cyc < 300) begin
            sob = (sbq.size() == 65);
            e = sbq[0];
            total++;
            if (zid_vld !== 1'b1 || zid !== e.id || zid_last !== e.last) begin
                bad++;
                $display("FAIL b2b_beat got vld=%b zid=%0d last=%b want vld=1 zid=%0d last=%b", zid_vld, zid, zid_last, e.id, e.last);
            end
            e = sbq.pop_front();
            cyc++;
            @(negedge clk);
        end
        sob = 1'b0;
        total++;
        if (sbq.size() != 0 || zid_vld !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end got left=%0d vld=%b want left=0 vld=0", sbq.size(), zid_vld);
        end
        sbq.delete();
    endtask

    task automatic test_abort();
        int cyc = 0;
        int after = 0;
        bit aborted = 1'b0;
        push_block(0);
        @(negedge clk); sob = 1'b1; mode = 2'd0; zid_rdy = 1'b1;
        @(negedge clk); sob = 1'b0;
        while (sbq.size() > 0 && cyc < 300) begin
            sob = !aborted && (sbq.size() == 44);
            mode = 2'd2;
            e = sbq[0];
            total++;
            if (zid_vld !== 1'b1 || zid !== e.id || zid_last !== e.last) begin
                bad++;
                $display("FAIL abort_beat got vld=%b zid=%0d last=%b want vld=1 zid=%0d last=%b", zid_vld, zid, zid_last, e.id, e.last);
            end
            e = sbq.pop_front();
            if (aborted) after++;
            if (sob) begin
                sbq.delete();
                push_block(2);
                aborted = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        sob = 1'b0;
        total++;
        if (after != 64 || zid_vld !== 1'b0) begin
            bad++;
            $display("FAIL abort_count got after=%0d vld=%b want 64 and 0", after, zid_vld);
        end
        sbq.delete();
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        push_block(0);
        @(negedge clk); sob = 1'b1; mode = 2'd0; zid_rdy = 1'b1;
        @(negedge clk); sob = 1'b0;
        while (sbq.size() > 34 && cyc < 100) begin
            e = sbq.pop_front();
            cyc++;
            @(negedge clk);
        end
        total++;
        if (zid !== 6'd30 || zid_vld !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pos got zid=%0d vld=%b want 30 and 1", zid, zid_vld);
        end
        #1 rstn = 1'b0;
        #1;
        total++;
        if (zid_vld !== 1'b0 || zid !== 6'd0 || zid_last !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_clear got vld=%b zid=%0d last=%b busy=%b want all 0", zid_vld, zid, zid_last, busy);
        end
        sbq.delete();
        @(negedge clk); rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (zid_vld !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid_idle got vld=%b want 0", zid_vld);
            end
        end
    endtask

    initial begin
        build_zz();
        test_reset();
        test_order("morton", 2'd1);
        test_order("zigzag", 2'd3);
        test_order("raster", 2'd0);
        test_column_stall();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
